// File: rtl/snn_inference_sequencer_pkg.sv
// Shared types and constants for the SNN inference sequencer.
package snn_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_PRESENT,
        S_DECIDE,
        S_RESULT,
        S_REST
    } seq_state_t;

    localparam int DEFAULT_PRESENT_CYCLES = 100;
    localparam int DEFAULT_REST_CYCLES    = 10;

    // Width of a class index; never narrower than one bit.
    function automatic int class_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/snn_inference_sequencer_if.sv
// Result handshake bundle: sequencer drives the result, consumer returns ready.
interface snn_inference_sequencer_if
    import snn_seq_pkg::*;
#(
    parameter int NUM_CLASSES = 3,
    parameter int CNT_W       = 8
) ();
    localparam int CLS_W = class_w(NUM_CLASSES);

    logic             result_valid;
    logic             result_ready;
    logic [CLS_W-1:0] result_class;
    logic [CNT_W-1:0] result_count;
    logic             result_tie;
    logic             result_none;

    modport master (
        output result_valid, result_class, result_count, result_tie, result_none,
        input  result_ready
    );

    modport slave (
        input  result_valid, result_class, result_count, result_tie, result_none,
        output result_ready
    );
endinterface

// File: rtl/snn_inference_sequencer_counter.sv
// Per-class spike counter: synchronous clear, increment enable, saturates at all-ones.
module spike_counter_sat #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clear)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + CNT_W'(1);
    end
endmodule

// File: rtl/snn_inference_sequencer.sv
// Sequences one SNN inference: clear, present, count spikes, pick winner, hand off, rest.
module snn_inference_sequencer
    import snn_seq_pkg::*;
#(
    parameter int NUM_CLASSES    = 3,
    parameter int PRESENT_CYCLES = DEFAULT_PRESENT_CYCLES,
    parameter int REST_CYCLES    = DEFAULT_REST_CYCLES,
    parameter int CNT_W          = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [3:0]             pattern_in,
    input  logic [NUM_CLASSES-1:0] out_spikes,
    output logic [3:0]             pattern_out,
    output logic                   enc_enable,
    output logic                   neuron_clear,
    output logic                   busy,
    snn_inference_sequencer_if.master res
);
    localparam int CLS_W   = class_w(NUM_CLASSES);
    localparam int MAX_CYC = (PRESENT_CYCLES > REST_CYCLES) ? PRESENT_CYCLES : REST_CYCLES;
    localparam int CYC_W   = $clog2(MAX_CYC + 1);

    seq_state_t             state;
    logic [CYC_W-1:0]       cyc_cnt;
    logic                   cnt_clear;
    logic [NUM_CLASSES-1:0] cnt_inc;
    logic [CNT_W-1:0]       counts [NUM_CLASSES];

    // Counters are wiped on reset and on every accepted start; spikes only count in PRESENT.
    assign cnt_clear = rst || ((state == S_IDLE) && start);
    assign cnt_inc   = (state == S_PRESENT) ? out_spikes : '0;

    for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_cnt
        spike_counter_sat #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .clear (cnt_clear),
            .inc   (cnt_inc[i]),
            .count (counts[i])
        );
    end

    logic [CLS_W-1:0] best_idx;
    logic [CNT_W-1:0] best_cnt;
    logic             best_tie;

    // Strict '>' keeps the lowest index on ties; tie resets whenever a new maximum appears.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        best_idx = '0;
        best_cnt = counts[0];
        best_tie = 1'b0;
        for (int i = 1; i < NUM_CLASSES; i++) begin
            if (counts[i] > best_cnt) begin
                best_idx = CLS_W'(i);
                best_cnt = counts[i];
                best_tie = 1'b0;
            end else if (counts[i] == best_cnt) begin
                best_tie = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            cyc_cnt          <= '0;
            pattern_out      <= '0;
            enc_enable       <= 1'b0;
            neuron_clear     <= 1'b0;
            busy             <= 1'b0;
            res.result_valid <= 1'b0;
            res.result_class <= '0;
            res.result_count <= '0;
            res.result_tie   <= 1'b0;
            res.result_none  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    pattern_out  <= pattern_in;
                    neuron_clear <= 1'b1;
                    busy         <= 1'b1;
                    state        <= S_CLEAR;
                end
                S_CLEAR: begin
                    neuron_clear <= 1'b0;
                    enc_enable   <= 1'b1;
                    cyc_cnt      <= CYC_W'(PRESENT_CYCLES - 1);
                    state        <= S_PRESENT;
                end
                S_PRESENT: if (cyc_cnt == '0) begin
                    enc_enable <= 1'b0;
                    state      <= S_DECIDE;
                end else begin
                    cyc_cnt <= cyc_cnt - CYC_W'(1);
                end
                S_DECIDE: begin
                    res.result_valid <= 1'b1;
                    res.result_none  <= (best_cnt == '0);
                    res.result_class <= (best_cnt == '0) ? '0 : best_idx;
                    res.result_count <= best_cnt;
                    res.result_tie   <= (best_cnt == '0) ? 1'b0 : best_tie;
                    state            <= S_RESULT;
                end
                S_RESULT: if (res.result_ready) begin
                    res.result_valid <= 1'b0;
                    neuron_clear     <= 1'b1;
                    cyc_cnt          <= CYC_W'(REST_CYCLES - 1);
                    state            <= S_REST;
                end
                S_REST: if (cyc_cnt == '0) begin
                    neuron_clear <= 1'b0;
                    busy         <= 1'b0;
                    state        <= S_IDLE;
                end else begin
                    cyc_cnt <= cyc_cnt - CYC_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snn_inference_sequencer.sv
// Self-checking bench: timestamp-based behavioural model compared every cycle, plus literal pins.
module tb_snn_inference_sequencer;
    import snn_seq_pkg::*;

    localparam int NC  = 3;
    localparam int P   = 100;
    localparam int R   = 10;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    typedef struct {
        int cls;
        int cnt;
        bit tie;
        bit none;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [3:0]    pattern_in;
    logic [NC-1:0] out_spikes;
    logic [3:0]    pattern_out;
    logic          enc_enable;
    logic          neuron_clear;
    logic          busy;

    snn_inference_sequencer_if #(.NUM_CLASSES(NC), .CNT_W(CW)) res_if ();

    snn_inference_sequencer #(
        .NUM_CLASSES(NC), .PRESENT_CYCLES(P), .REST_CYCLES(R), .CNT_W(CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pattern_in   (pattern_in),
        .out_spikes   (out_spikes),
        .pattern_out  (pattern_out),
        .enc_enable   (enc_enable),
        .neuron_clear (neuron_clear),
        .busy         (busy),
        .res          (res_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Model: an inference is described by its start edge and (later) its transfer edge.
    int         cyc = 0;
    bit         m_active = 1'b0;
    bit         m_xfer = 1'b0;
    int         m_t = 0;
    int         m_e = 0;
    int         m_cnt [NC];
    logic [3:0] m_pat = 4'd0;

    function automatic res_t model_result();
        res_t r;
        int   mx = 0;
        int   n_at = 0;
        r = '{cls: 0, cnt: 0, tie: 1'b0, none: 1'b0};
        for (int i = 0; i < NC; i++) if (m_cnt[i] > mx) mx = m_cnt[i];
        if (mx == 0) begin
            r.none = 1'b1;
        end else begin
            for (int i = NC - 1; i >= 0; i--) begin
                if (m_cnt[i] == mx) begin
                    r.cls = i;
                    n_at++;
                end
            end
            r.cnt = mx;
            r.tie = (n_at >= 2);
        end
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_active = 1'b0;
                m_xfer   = 1'b0;
                m_pat    = 4'd0;
            end else if (!m_active) begin
                if (start) begin
                    m_active = 1'b1;
                    m_xfer   = 1'b0;
                    m_t      = cyc;
                    m_pat    = pattern_in;
                    for (int i = 0; i < NC; i++) m_cnt[i] = 0;
                end
            end else if (m_xfer) begin
                if (cyc - m_e == R) m_active = 1'b0;
            end else begin
                if ((cyc - m_t >= 2) && (cyc - m_t <= P + 1)) begin
                    for (int i = 0; i < NC; i++)
                        if (out_spikes[i] && m_cnt[i] < SAT) m_cnt[i]++;
                end else if ((cyc - m_t >= P + 3) && res_if.result_ready) begin
                    m_xfer = 1'b1;
                    m_e    = cyc;
                end
            end
        end
    end

    // Per-cycle compare on the falling edge, after the model has absorbed the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                int         rel;
                logic       e_busy, e_clear, e_enc, e_valid;
                res_t       mr;
                logic [7:0] e_fields;
                rel     = cyc - m_t;
                e_busy  = m_active;
                e_clear = m_active && (m_xfer || rel == 0);
                e_enc   = m_active && !m_xfer && rel >= 1 && rel <= P;
                e_valid = m_active && !m_xfer && rel >= P + 2;
                check("cycle_outputs{pat,enc,clr,busy,valid}",
                      {pattern_out, enc_enable, neuron_clear, busy, res_if.result_valid},
                      {m_pat, e_enc, e_clear, e_busy, e_valid});
                if (e_valid) begin
                    mr = model_result();
                    e_fields = {2'(mr.cls), 4'(mr.cnt), mr.tie, mr.none};
                    check("cycle_result_fields{cls,cnt,tie,none}",
                          {res_if.result_class, res_if.result_count,
                           res_if.result_tie, res_if.result_none},
                          e_fields);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full inference. Spike table: class i spikes on the first k[i] PRESENT cycles,
    // or randomly when rnd is set. Returns DUT and model results sampled at valid.
    task automatic run_inference(input logic [3:0] pat, input int k0, input int k1,
                                 input int k2, input bit rnd, input int hold,
                                 input bit early_ready, output res_t dut_r,
                                 output res_t mod_r, output int lat, output int rest_n);
        int n;
        start      = 1'b1;
        pattern_in = pat;
        tick();
        start      = 1'b0;
        pattern_in = 4'($urandom);
        out_spikes = '1;                        // stray, during CLEAR
        tick();
        for (int k = 0; k < P; k++) begin
            if (rnd) begin
                for (int i = 0; i < NC; i++) out_spikes[i] = ($urandom_range(0, 7) == 0);
                start = ($urandom_range(0, 7) == 0);
            end else begin
                out_spikes = {k < k2, k < k1, k < k0};
                start = (k == 40);
            end
            tick();
        end
        out_spikes = '1;                        // stray, during DECIDE
        start = 1'b0;
        res_if.result_ready = early_ready;
        tick();
        out_spikes = '0;
        n = 0;
        while (!res_if.result_valid && n < 300) begin
            tick();
            n++;
        end
        check("result_valid_timeout", {63'd0, res_if.result_valid}, 64'd1);
        lat   = cyc - m_t;
        dut_r = '{cls: int'(res_if.result_class), cnt: int'(res_if.result_count),
                  tie: res_if.result_tie, none: res_if.result_none};
        mod_r = model_result();
        if (!early_ready) begin
            repeat (hold) tick();
            res_if.result_ready = 1'b1;
        end
        tick();
        res_if.result_ready = 1'b0;
        rest_n = 0;
        n = 0;
        while (busy && n < 50) begin
            if (neuron_clear) rest_n++;
            out_spikes = NC'($urandom);
            start = 1'($urandom);
            tick();
            n++;
        end
        check("busy_drop_timeout", {63'd0, busy}, 64'd0);
        start      = 1'b0;
        out_spikes = '0;
    endtask

    task automatic pin(input string name, input res_t dr, input res_t mr, input int cls,
                       input int cnt, input bit tie, input bit none);
        check({name, "_dut"}, {dr.cls[7:0], dr.cnt[7:0], 7'd0, dr.tie, 7'd0, dr.none},
              {cls[7:0], cnt[7:0], 7'd0, tie, 7'd0, none});
        check({name, "_model"}, {mr.cls[7:0], mr.cnt[7:0], 7'd0, mr.tie, 7'd0, mr.none},
              {cls[7:0], cnt[7:0], 7'd0, tie, 7'd0, none});
    endtask

    initial begin
        res_t dr, mr;
        int   lat, rest_n;
        rst        = 1'b1;
        start      = 1'b0;
        pattern_in = 4'd0;
        out_spikes = '0;
        res_if.result_ready = 1'b0;
        repeat (3) tick();
        check("reset_state",
              {pattern_out, enc_enable, neuron_clear, busy, res_if.result_valid,
               res_if.result_class, res_if.result_count, res_if.result_tie, res_if.result_none},
              64'd0);
        rst = 1'b0;
        tick();

        run_inference(4'b1011, 5, 12, 0, 1'b0, 0, 1'b0, dr, mr, lat, rest_n);
        pin("basic", dr, mr, 1, 12, 1'b0, 1'b0);
        check("basic_valid_latency", 64'(lat), 64'd102);
        check("basic_pattern_out", {60'd0, pattern_out}, 64'hb);

        run_inference(4'b0110, 7, 3, 7, 1'b0, 0, 1'b0, dr, mr, lat, rest_n);
        pin("tie", dr, mr, 0, 7, 1'b1, 1'b0);

        run_inference(4'b0001, 0, 0, 0, 1'b0, 0, 1'b0, dr, mr, lat, rest_n);
        pin("none", dr, mr, 0, 0, 1'b0, 1'b1);

        run_inference(4'b1111, 0, 0, 100, 1'b0, 0, 1'b0, dr, mr, lat, rest_n);
        pin("saturate", dr, mr, 2, SAT, 1'b0, 1'b0);

        run_inference(4'b1000, 1, 2, 3, 1'b0, 20, 1'b0, dr, mr, lat, rest_n);
        pin("backpressure", dr, mr, 2, 3, 1'b0, 1'b0);
        check("backpressure_rest_cycles", 64'(rest_n), 64'(R));

        // Reset in the middle of PRESENT, then a fresh inference.
        start      = 1'b1;
        pattern_in = 4'b0101;
        tick();
        start = 1'b0;
        tick();
        repeat (50) begin
            out_spikes = NC'($urandom);
            tick();
        end
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        out_spikes = '0;
        check("reset_mid_present",
              {pattern_out, enc_enable, neuron_clear, busy, res_if.result_valid,
               res_if.result_class, res_if.result_count, res_if.result_tie, res_if.result_none},
              64'd0);
        tick();
        run_inference(4'b0011, 4, 9, 9, 1'b0, 0, 1'b1, dr, mr, lat, rest_n);
        pin("after_reset", dr, mr, 1, 9, 1'b1, 1'b0);
        check("early_ready_rest_cycles", 64'(rest_n), 64'(R));

        for (int it = 0; it < 8; it++) begin
            run_inference(4'($urandom), 0, 0, 0, 1'b1, $urandom_range(0, 5),
                          1'($urandom), dr, mr, lat, rest_n);
            check("random_latency", 64'(lat), 64'(P + 2));
            check("random_rest_cycles", 64'(rest_n), 64'(R));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/snn_inference_sequencer.md
# snn_inference_sequencer

Sequences one inference of the 4-pixel SNN: latches a pattern, clears neuron state, enables the AER pixel encoder for a fixed presentation window, counts output-layer spikes per class, selects the winning class, and presents the result on a valid/ready handshake before a rest period. It sits between the host/testbench stimulus and the encoder → hidden → output neuron datapath. It owns the encoder `enable` and the neuron state-clear line.

## Interface
- `NUM_CLASSES`, 3, number of output neurons / classes (2..8)
- `PRESENT_CYCLES`, 100, cycles the encoder is enabled per inference (≥1)
- `REST_CYCLES`, 10, cycles neurons are held cleared after the result is taken (≥1)
- `CNT_W`, 8, per-class spike counter width
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request an inference; sampled only in IDLE
- `pattern_in`  in  4  pixel pattern, captured on accepted `start`
- `out_spikes`  in  NUM_CLASSES  output-neuron spike pulses, one bit per class
- `pattern_out`  out  4  latched pattern driven to encoder pixel inputs
- `enc_enable`  out  1  AER encoder enable
- `neuron_clear`  out  1  forces all neuron membrane potentials to 0
- `busy`  out  1  high in every state except IDLE
- `result_valid`  out  1  result fields valid
- `result_ready`  in  1  consumer accepts result
- `result_class`  out  clog2(NUM_CLASSES)  winning class index
- `result_count`  out  CNT_W  spike count of winning class
- `result_tie`  out  1  ≥2 classes share the maximum count
- `result_none`  out  1  all counts zero

## Operation
- States: IDLE → CLEAR → PRESENT → DECIDE → RESULT → REST → IDLE.
- IDLE: `start`=1 latches `pattern_in` into `pattern_out`, zeroes all counters, → CLEAR. Otherwise remain.
- CLEAR: exactly 1 cycle, `neuron_clear`=1, → PRESENT.
- PRESENT: `enc_enable`=1 for exactly PRESENT_CYCLES cycles (down-counter). Each cycle, every class with `out_spikes[i]`=1 increments its counter. Counters saturate at 2^CNT_W−1. After the last cycle → DECIDE.
- DECIDE: 1 cycle. Compute argmax over counters, breaking ties by the lowest index. Register `result_class`, `result_count`, `result_tie`, and `result_none`; `result_none`=1 forces class 0, count 0, tie 0. → RESULT.
- RESULT: `result_valid`=1, fields stable. Transfer occurs when `result_valid` and `result_ready` are both high on the same edge; then → REST.
- REST: `neuron_clear`=1 for REST_CYCLES cycles, then → IDLE.
- `out_spikes` is ignored outside PRESENT. `start` is ignored while `busy`.
- `pattern_out` holds its value until the next accepted `start`.

## Timing
- Reset values: state IDLE; `pattern_out`=0; `enc_enable`, `neuron_clear`, `busy`, `result_valid`, `result_tie`, `result_none` = 0; `result_class`=0; `result_count`=0; counters 0.
- All outputs are registered, with no combinational input→output paths.
- Cycle timing, with `start` sampled high at edge t:
  - CLEAR during t+1.
  - PRESENT during t+2 … t+1+PRESENT_CYCLES.
  - DECIDE at t+2+PRESENT_CYCLES.
  - `result_valid` high from t+3+PRESENT_CYCLES.
- Spikes are counted on the same edge they are sampled. A spike on the final PRESENT cycle is included.
- `result_ready` may be high before `result_valid`. Minimum RESULT residency is 1 cycle.
- `result_valid` drops the cycle after the transfer. REST lasts REST_CYCLES cycles. `busy` falls on the first IDLE cycle, where a new `start` is accepted.
- `rst` mid-operation returns to IDLE next edge with reset values; any pending result is discarded.
- Simultaneous spikes on all classes in one cycle each increment their own counter.

## Structure
- Package `snn_seq_pkg`: state enum type, class-index width function (clog2), shared default constants for PRESENT_CYCLES/REST_CYCLES.
- Sub-module `spike_counter_sat`: CNT_W counter with sync clear, increment enable, saturation; instantiated NUM_CLASSES times.
- Argmax is a combinational loop inside the top, registered in DECIDE.

## Test plan
- Basic run: PRESENT_CYCLES=100, `start` with pattern 4'b1011, class 1 spikes 12×, class 0 spikes 5×, class 2 spikes 0× → class 1, count 12, tie 0, none 0. `result_valid` rises at t+103.
- Tie: classes 0 and 2 each spike 7×, class 1 spikes 3× → class 0, count 7, tie 1.
- No activity and saturation:
  - No spikes → class 0, count 0, none 1.
  - CNT_W=4 with class 2 spiking every PRESENT cycle → count 15, class 2.
- Backpressure: hold `result_ready`=0 for 20 cycles → `result_valid` and fields stable. Then `result_ready`=1 → one transfer, REST of exactly 10 cycles with `neuron_clear`=1, `busy` low at the next cycle.
- Ignored and stray inputs:
  - `start` pulses during PRESENT/REST → no effect on counts or sequence.
  - `out_spikes` asserted in IDLE/CLEAR/REST → not counted.
- Reset mid-PRESENT: assert `rst` at cycle t+50 → next edge all outputs at reset values. A new `start` then produces a correct, fresh result.
